// File: rtl/fp_pkg.sv
// fp_pkg: shared FSM state type and IEEE-754 single-precision constants.
package fp_pkg;
    typedef enum logic [1:0] {IDLE, CALC, HOLD} fp_state_t;
    localparam logic [31:0] FP_NAN  = 32'hFFFF_FFFF;
    localparam logic [31:0] FP_PINF = 32'h7F80_0000;
    localparam logic [31:0] FP_NINF = 32'hFF80_0000;
endpackage

// File: rtl/adder_unit.sv
// adder_unit: combinational IEEE-754 single-precision adder, round-to-nearest-even.
module adder_unit
    import fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    logic        swap, a_nan, b_nan, a_inf, b_inf, lz_ok, rup;
    logic [31:0] l, s;
    logic [7:0]  el, es, diff;
    logic [4:0]  d, lz;
    logic [26:0] ml, ms, ms_sh, m;
    logic [53:0] wide;
    logic [27:0] s_raw;
    logic [8:0]  e;
    logic [30:0] rnd;
    always_comb begin
        a_nan = a[30:23] == 8'hFF && a[22:0] != 23'd0;
        b_nan = b[30:23] == 8'hFF && b[22:0] != 23'd0;
        a_inf = a[30:23] == 8'hFF && a[22:0] == 23'd0;
        b_inf = b[30:23] == 8'hFF && b[22:0] == 23'd0;
        swap  = b[30:0] > a[30:0];
        l     = swap ? b : a;
        s     = swap ? a : b;
        el    = l[30:23] == 8'd0 ? 8'd1 : l[30:23];
        es    = s[30:23] == 8'd0 ? 8'd1 : s[30:23];
        ml    = {|l[30:23], l[22:0], 3'b000};
        ms    = {|s[30:23], s[22:0], 3'b000};
        diff  = el - es;
        d     = diff > 8'd27 ? 5'd27 : diff[4:0];
        // bits shifted past the guard/round positions collapse into the sticky bit
        wide  = {ms, 27'd0} >> d;
        ms_sh = wide[53:27] | {26'd0, |wide[26:0]};
        s_raw = l[31] == s[31] ? {1'b0, ml} + {1'b0, ms_sh} : {1'b0, ml} - {1'b0, ms_sh};
        lz    = 5'd27;
        for (int i = 0; i < 27; i++)
            if (s_raw[i]) lz = 5'(26 - i);
        lz_ok = {3'b000, lz} < el;
        m     = s_raw[27] ? {s_raw[27:2], |s_raw[1:0]} :
                lz_ok     ? s_raw[26:0] << lz : s_raw[26:0] << (el - 8'd1);
        e     = s_raw[27] ? {1'b0, el} + 9'd1 :
                lz_ok     ? {1'b0, el} - {4'd0, lz} : 9'd0;
        rup   = m[2] & (m[1] | m[0] | m[3]);
        // a mantissa carry from rounding ripples straight into the exponent field
        rnd   = {e[7:0], m[25:3]} + {30'd0, rup};
        sum   = (a_nan || b_nan || (a_inf && b_inf && a[31] != b[31])) ? FP_NAN :
                a_inf                ? a :
                b_inf                ? b :
                s_raw == 28'd0       ? {a[31] & b[31], 31'd0} :
                e[7:0] == 8'hFF      ? {l[31], FP_PINF[30:0]} : {l[31], rnd};
    end
endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one FP adder between two requesters,
// with registered operands/result and a backpressured result channel.
module fp_add_arbiter
    import fp_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_id,
    output logic             res_nan,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    fp_state_t   state, state_nx;
    logic [31:0] op_a, op_b, sum;
    logic        op_id, last_gnt, gnt, gnt_id;

    adder_unit u_add (.a(op_a), .b(op_b), .sum(sum));

    assign gnt      = req0_valid | req1_valid;
    // on a conflict the requester that did not win last time goes first
    assign gnt_id   = (req0_valid & req1_valid) ? ~last_gnt : req1_valid;
    assign res_nan  = res_data == FP_NAN;
    assign busy     = state != IDLE;

    always_comb begin
        req0_ready = state == IDLE && gnt && !gnt_id;
        req1_ready = state == IDLE && gnt && gnt_id;
        state_nx   = state == IDLE ? (gnt ? CALC : IDLE) :
                     state == CALC ? HOLD : (res_ready ? IDLE : HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= 1'b0;
            last_gnt  <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
            cnt0      <= '0;
            cnt1      <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && gnt) begin
                op_a     <= gnt_id ? req1_a : req0_a;
                op_b     <= gnt_id ? req1_b : req0_b;
                op_id    <= gnt_id;
                last_gnt <= gnt_id;
            end
            if (state == CALC) begin
                res_data  <= sum;
                res_id    <= op_id;
                res_valid <= 1'b1;
            end
            if (state == HOLD && res_ready) begin
                res_valid <= 1'b0;
                cnt0      <= cnt0 + CNT_W'(!res_id);
                cnt1      <= cnt1 + CNT_W'(res_id);
            end
        end
    end
endmodule
